// File: rtl/binary_mul_6_frame_acc_if.sv
// Operand, multiplier and frame-sum signals for binary_mul_6_frame_acc.
// slave is the block's view; master is the issuer/multiplier/consumer side.
interface binary_mul_6_frame_acc_if #(parameter int ACC_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_a;
  logic [5:0]       in_b;
  logic [5:0]       mul_a;
  logic [5:0]       mul_b;
  logic             mul_en;
  logic [11:0]      mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;

  modport slave (
    input  in_valid, in_a, in_b, mul_p, out_ready,
    output in_ready, mul_a, mul_b, mul_en, out_valid, out_sum
  );
  modport master (
    output in_valid, in_a, in_b, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, mul_en, out_valid, out_sum
  );
endinterface

// File: rtl/binary_mul_6_frame_acc.sv
// Issues operand pairs to a fixed-latency 6x6 multiplier, sums each frame of
// LEN products and holds the frame sum in a valid/ready output register.
module binary_mul_6_frame_acc #(
  parameter int LATENCY = 7,
  parameter int LEN     = 4,
  parameter int ACC_W   = 16
) (
  input logic                    clk,
  input logic                    rst,
  binary_mul_6_frame_acc_if.slave bus
);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t           state;
  // The multiplier samples mul_a one edge after acceptance and its product
  // appears LATENCY edges later, so tags need LATENCY+1 stages.
  logic [LATENCY:0] tag, last_tag;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] icnt;
  logic             pend;

  logic             take, is_last, out_free;
  logic [ACC_W-1:0] sum;

  assign take     = bus.in_valid & bus.in_ready;
  assign is_last  = (icnt == CNT_W'(LEN - 1));
  assign out_free = ~bus.out_valid | bus.out_ready;
  assign sum      = acc + ACC_W'(bus.mul_p);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      tag           <= '0;
      last_tag      <= '0;
      acc           <= '0;
      icnt          <= '0;
      pend          <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.mul_en    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
    end else begin
      bus.mul_en <= 1'b1;
      tag        <= {tag[LATENCY-1:0], take};
      last_tag   <= {last_tag[LATENCY-1:0], take & is_last};
      if (state == ACCUM) bus.in_ready <= 1'b1;

      if (take) begin
        bus.mul_a <= bus.in_a;
        bus.mul_b <= bus.in_b;
        if (is_last) begin
          icnt         <= '0;
          state        <= DRAIN;
          bus.in_ready <= 1'b0;
        end else begin
          icnt <= icnt + CNT_W'(1);
        end
      end

      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

      // A reload below overrides the handoff clear above.
      if (tag[LATENCY]) begin
        if (last_tag[LATENCY] && out_free) begin
          bus.out_sum   <= sum;
          bus.out_valid <= 1'b1;
          acc           <= '0;
          state         <= ACCUM;
          bus.in_ready  <= 1'b1;
        end else begin
          acc <= sum;
          if (last_tag[LATENCY]) pend <= 1'b1;
        end
      end else if (pend && out_free) begin
        bus.out_sum   <= acc;
        bus.out_valid <= 1'b1;
        acc           <= '0;
        pend          <= 1'b0;
        state         <= ACCUM;
        bus.in_ready  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_binary_mul_6_frame_acc.sv
// Bench for binary_mul_6_frame_acc: multiplier model, frame-sum scoreboard,
// directed corner cases and randomized frames with random backpressure.
module tb_binary_mul_6_frame_acc;
  localparam int LAT = 7;
  localparam int LEN = 4;
  localparam int AW  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binary_mul_6_frame_acc_if #(.ACC_W(AW)) b1();
  binary_mul_6_frame_acc_if #(.ACC_W(AW)) b2();

  binary_mul_6_frame_acc #(.LATENCY(LAT), .LEN(LEN), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(b1));
  binary_mul_6_frame_acc #(.LATENCY(LAT), .LEN(16), .ACC_W(AW)) dut16 (
    .clk(clk), .rst(rst), .bus(b2));

  // Free-running multiplier models: sample on enable, product LAT edges later.
  logic [11:0] pp1 [LAT];
  logic [11:0] pp2 [LAT];
  always @(posedge clk) begin
    if (b1.mul_en) begin
      pp1[0] <= 12'(b1.mul_a) * 12'(b1.mul_b);
      for (int i = 1; i < LAT; i++) pp1[i] <= pp1[i-1];
    end
    if (b2.mul_en) begin
      pp2[0] <= 12'(b2.mul_a) * 12'(b2.mul_b);
      for (int i = 1; i < LAT; i++) pp2[i] <= pp2[i-1];
    end
  end
  assign b1.mul_p = pp1[LAT-1];
  assign b2.mul_p = pp2[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: frame sums from accepted operands, popped at each output handoff.
  int unsigned    q[$];
  int unsigned    fsum;
  int             fcnt;
  logic           hold_prev = 1'b0;
  logic [AW-1:0]  sum_prev;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      fsum = 0;
      fcnt = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_vld", 32'(b1.out_valid), 1);
        chk("hold_sum", 32'(b1.out_sum), 32'(sum_prev));
      end
      if (b1.in_valid && b1.in_ready) begin
        fsum += int'(b1.in_a) * int'(b1.in_b);
        fcnt++;
        if (fcnt == LEN) begin
          q.push_back(fsum);
          fsum = 0;
          fcnt = 0;
        end
      end
      if (b1.out_valid && b1.out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else chk("sb_sum", 32'(b1.out_sum), q.pop_front());
      end
      hold_prev = b1.out_valid && !b1.out_ready;
      sum_prev  = b1.out_sum;
    end
  end

  logic rnd_bp = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd_bp) b1.out_ready = 1'($urandom);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [5:0] a, input logic [5:0] b);
    int   t = 0;
    logic ok;
    b1.in_valid = 1'b1; b1.in_a = a; b1.in_b = b;
    do begin
      @(negedge clk); ok = b1.in_ready;
      @(posedge clk); #1; t++;
    end while (!ok && t < 100);
    if (!ok) chk("send_tmo", 0, 1);
    b1.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!b1.out_valid && k < 100) begin @(posedge clk); #1; k++; end
    if (!b1.out_valid) chk("out_tmo", 0, 1);
  endtask

  task automatic frame70();
    send(1, 5); send(2, 6); send(3, 7); send(4, 8);
  endtask

  // LEN=16 instance: sixteen (63,63) products must sum to 63504 without wrap.
  logic done2 = 1'b0;
  initial begin
    int   n, t, k;
    logic ok;
    b2.in_valid = 1'b0; b2.in_a = '0; b2.in_b = '0; b2.out_ready = 1'b1;
    @(negedge rst);
    n = 0; t = 0;
    b2.in_a = 6'd63; b2.in_b = 6'd63; b2.in_valid = 1'b1;
    while (n < 16 && t < 200) begin
      @(negedge clk); ok = b2.in_ready;
      @(posedge clk); #1; t++;
      if (ok) n++;
    end
    b2.in_valid = 1'b0;
    chk("len16_feed", 32'(n), 16);
    k = 0;
    while (!b2.out_valid && k < 100) begin @(posedge clk); #1; k++; end
    chk("len16_vld", 32'(b2.out_valid), 1);
    chk("len16_sum", 32'(b2.out_sum), 63504);
    done2 = 1'b1;
  end

  initial begin
    int k;
    rst = 1'b1;
    b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rst_in_ready", 32'(b1.in_ready), 0);
    chk("rst_mul_en", 32'(b1.mul_en), 0);
    chk("rst_mul_a", 32'(b1.mul_a), 0);
    chk("rst_mul_b", 32'(b1.mul_b), 0);
    chk("rst_out_valid", 32'(b1.out_valid), 0);
    chk("rst_out_sum", 32'(b1.out_sum), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    chk("rdy_after_rst", 32'(b1.in_ready), 1);
    chk("en_after_rst", 32'(b1.mul_en), 1);

    // Basic frame: latency and single-cycle valid pulse.
    frame70();
    chk("rdy_drain", 32'(b1.in_ready), 0);
    wait_out(k);
    chk("latency", 32'(k), LAT + 1);
    chk("sum70", 32'(b1.out_sum), 70);
    idle(1);
    chk("vld_1cyc", 32'(b1.out_valid), 0);

    repeat (4) send(63, 63);
    wait_out(k);
    chk("sum_max4", 32'(b1.out_sum), 15876);
    idle(1);

    // Backpressure across two frames.
    b1.out_ready = 1'b0;
    frame70();
    repeat (4) send(1, 1);
    idle(12);
    chk("bp_sum", 32'(b1.out_sum), 70);
    chk("bp_vld", 32'(b1.out_valid), 1);
    chk("bp_rdy", 32'(b1.in_ready), 0);
    b1.out_ready = 1'b1;
    idle(1);
    chk("bp_2nd_sum", 32'(b1.out_sum), 4);
    chk("bp_2nd_vld", 32'(b1.out_valid), 1);
    chk("bp_rdy_back", 32'(b1.in_ready), 1);
    idle(1);
    chk("bp_done", 32'(b1.out_valid), 0);

    // Gappy input over three frames.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) begin
        idle($urandom_range(0, 3));
        send(10, 10);
      end
      wait_out(k);
      chk("gap_sum", 32'(b1.out_sum), 400);
      idle(1);
    end

    // Random operands with random backpressure, checked by the scoreboard.
    rnd_bp = 1'b1;
    for (int f = 0; f < 6; f++)
      for (int i = 0; i < 4; i++) begin
        idle($urandom_range(0, 2));
        send(6'($urandom), 6'($urandom));
      end
    rnd_bp = 1'b0;
    b1.out_ready = 1'b1;
    idle(30);
    chk("rnd_drained", 32'(q.size()), 0);

    // Reset with a held output and a partial frame in flight.
    b1.out_ready = 1'b0;
    frame70();
    idle(12);
    send(1, 1); send(1, 1);
    idle(2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_clr_vld", 32'(b1.out_valid), 0);
    chk("rst_clr_sum", 32'(b1.out_sum), 0);
    b1.out_ready = 1'b1;
    idle(2);
    repeat (4) send(2, 3);
    wait_out(k);
    chk("post_rst_sum", 32'(b1.out_sum), 24);
    idle(12);
    chk("no_stale", 32'(b1.out_valid), 0);

    // Handoff on the same edge as the next frame's final product.
    b1.out_ready = 1'b0;
    frame70();
    repeat (4) send(1, 1);
    idle(7);
    chk("coll_pre_sum", 32'(b1.out_sum), 70);
    b1.out_ready = 1'b1;
    idle(1);
    chk("coll_vld", 32'(b1.out_valid), 1);
    chk("coll_sum", 32'(b1.out_sum), 4);
    idle(3);
    chk("final_drained", 32'(q.size()), 0);

    k = 0;
    while (!done2 && k < 2000) begin idle(1); k++; end
    chk("len16_done", 32'(done2), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
